// File: rtl/param_clock.sv
`timescale 1ns/1ps
// param_clock: multiplexed 7-segment HH:MM[:SS] clock with button time setting.
// Ports:
//   clk      sole clock, rising edge
//   rst      asynchronous active-high reset
//   btn_set  set-mode button (1 = pressed, already synchronised)
//   btn_inc  increment button (1 = pressed, already synchronised), auto-repeats
//   h12      display mode, 1 = 12-hour, 0 = 24-hour
//   seg      seg[6:0] = segments a..g, seg[7] = decimal point, active high
//   d        digit select, active low one-cold, bit 0 = rightmost digit
module param_clock #(
    parameter int unsigned CLK_HZ       = 12000000,
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_BITS    = 10,
    parameter int unsigned BTN_BITS     = 15,
    parameter int unsigned REPEAT_DELAY = 16,
    parameter int unsigned REPEAT_RATE  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_set,
    input  logic                  btn_inc,
    input  logic                  h12,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] d
);

    localparam int unsigned DIV_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned FREE_W   = (SCAN_BITS > BTN_BITS) ? SCAN_BITS : BTN_BITS;
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int unsigned SEL_W    = $clog2(NUM_DIGITS);
    localparam int unsigned OFS      = NUM_DIGITS - 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DIV_W-1:0]        r_div;
    logic [FREE_W-1:0]       r_free;
    logic [1:0]              r_h2;
    logic [3:0]              r_h1;
    logic [2:0]              r_m2;
    logic [3:0]              r_m1;
    logic [5:0]              r_sec;
    logic                    r_set_q;
    logic                    r_inc_q;
    logic [HOLD_W-1:0]       r_hold;
    logic                    r_rpt_phase;
    logic [SEL_W-1:0]        r_sel;
    logic [NUM_DIGITS-1:0]   r_d;

    logic                    w_sample;
    logic                    w_set_ev;
    logic                    w_inc_press;
    logic                    w_inc_held;
    logic [HOLD_W-1:0]       w_hold_inc;
    logic                    w_rpt_ev;
    logic                    w_inc_ev;
    logic                    w_apply;
    logic                    w_tick;
    logic [1:0]              w_h2_inc;
    logic [3:0]              w_h1_inc;
    logic [2:0]              w_m2_inc;
    logic [3:0]              w_m1_inc;
    logic                    w_min_wrap;
    logic [4:0]              w_hour_bin;
    logic [4:0]              w_hour12;
    logic [3:0]              w_dh2;
    logic [3:0]              w_dh1;
    logic [3:0]              w_val;
    state_t                  w_fld;
    logic                    w_blank;
    logic                    w_dp;

    // Button sampling: events are rising edges between consecutive samples.
    assign w_sample    = (r_free[BTN_BITS-1:0] == '0);
    assign w_set_ev    = w_sample & btn_set & ~r_set_q;
    assign w_inc_press = w_sample & btn_inc & ~r_inc_q;
    assign w_inc_held  = w_sample & btn_inc & r_inc_q;
    assign w_hold_inc  = r_hold + HOLD_W'(1);
    // Phase 0 waits REPEAT_DELAY held samples, phase 1 repeats every REPEAT_RATE.
    assign w_rpt_ev    = w_inc_held & (r_rpt_phase ? (w_hold_inc == HOLD_W'(REPEAT_RATE))
                                                   : (w_hold_inc == HOLD_W'(REPEAT_DELAY)));
    assign w_inc_ev    = w_inc_press | w_rpt_ev;
    assign w_apply     = w_inc_ev & (r_state != ST_RUN);
    assign w_tick      = (r_div == DIV_W'(CLK_HZ - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_set_q     <= 1'b0;
            r_inc_q     <= 1'b0;
            r_hold      <= '0;
            r_rpt_phase <= 1'b0;
        end else if (w_sample) begin
            r_set_q <= btn_set;
            r_inc_q <= btn_inc;
            if (w_inc_press || w_rpt_ev) begin
                r_hold      <= '0;
                r_rpt_phase <= w_rpt_ev | r_rpt_phase & ~w_inc_press;
            end else if (w_inc_held) begin
                r_hold <= w_hold_inc;
            end else begin
                r_hold      <= '0;
                r_rpt_phase <= 1'b0;
            end
        end
    end

    // Set-mode state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    // Set-mode next state: one step per btn_set event
    always_comb begin
        w_state_nxt = r_state;
        if (w_set_ev) begin
            case (r_state)
                ST_RUN:      w_state_nxt = ST_SET_HOUR;
                ST_SET_HOUR: w_state_nxt = ST_SET_MIN;
                ST_SET_MIN:  w_state_nxt = (NUM_DIGITS == 6) ? ST_SET_SEC : ST_RUN;
                default:     w_state_nxt = ST_RUN;
            endcase
        end
    end

    // BCD increment helpers for hour (23 -> 00) and minute (59 -> 00)
    always_comb begin
        w_h2_inc = r_h2;
        w_h1_inc = r_h1 + 4'd1;
        if (r_h2 == 2'd2 && r_h1 == 4'd3) begin
            w_h2_inc = 2'd0;
            w_h1_inc = 4'd0;
        end else if (r_h1 == 4'd9) begin
            w_h2_inc = r_h2 + 2'd1;
            w_h1_inc = 4'd0;
        end
        w_min_wrap = (r_m2 == 3'd5) && (r_m1 == 4'd9);
        w_m2_inc   = r_m2;
        w_m1_inc   = r_m1 + 4'd1;
        if (r_m1 == 4'd9) begin
            w_m1_inc = 4'd0;
            w_m2_inc = (r_m2 == 3'd5) ? 3'd0 : r_m2 + 3'd1;
        end
    end

    // Timekeeping: a set-mode increment overrides a coincident tick and restarts the second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_sec <= '0;
            r_m1  <= '0;
            r_m2  <= '0;
            r_h1  <= '0;
            r_h2  <= '0;
        end else if (w_apply) begin
            r_div <= '0;
            r_sec <= '0;
            if (r_state == ST_SET_HOUR) begin
                r_h2 <= w_h2_inc;
                r_h1 <= w_h1_inc;
            end
            if (r_state == ST_SET_MIN) begin
                r_m2 <= w_m2_inc;
                r_m1 <= w_m1_inc;
            end
        end else if (w_tick) begin
            r_div <= '0;
            if (r_sec == 6'd59) begin
                r_sec <= '0;
                r_m2  <= w_m2_inc;
                r_m1  <= w_m1_inc;
                if (w_min_wrap) begin
                    r_h2 <= w_h2_inc;
                    r_h1 <= w_h1_inc;
                end
            end else begin
                r_sec <= r_sec + 6'd1;
            end
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Free-running counter: button sample strobe and digit scan rotation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_free <= '0;
            r_sel  <= '0;
            r_d    <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
        end else begin
            r_free <= r_free + FREE_W'(1);
            if (&r_free[SCAN_BITS-1:0]) begin
                r_d   <= {r_d[NUM_DIGITS-2:0], r_d[NUM_DIGITS-1]};
                r_sel <= (r_sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : r_sel + SEL_W'(1);
            end
        end
    end

    // Displayed hour digits, remapped for 12-hour mode
    always_comb begin
        w_hour_bin = 5'(r_h2) * 5'd10 + 5'(r_h1);
        w_hour12   = w_hour_bin;
        if (w_hour_bin == 5'd0)       w_hour12 = 5'd12;
        else if (w_hour_bin > 5'd12)  w_hour12 = w_hour_bin - 5'd12;
        if (h12) begin
            w_dh2 = 4'(w_hour12 / 5'd10);
            w_dh1 = 4'(w_hour12 % 5'd10);
        end else begin
            w_dh2 = 4'(r_h2);
            w_dh1 = r_h1;
        end
    end

    // Selected digit value, blanking and decimal point
    always_comb begin
        w_val   = 4'd0;
        w_fld   = ST_RUN;
        w_blank = 1'b0;
        w_dp    = 1'b0;
        if (r_sel == SEL_W'(OFS)) begin
            w_val = r_m1;
            w_fld = ST_SET_MIN;
        end else if (r_sel == SEL_W'(OFS + 1)) begin
            w_val = 4'(r_m2);
            w_fld = ST_SET_MIN;
        end else if (r_sel == SEL_W'(OFS + 2)) begin
            w_val = w_dh1;
            w_fld = ST_SET_HOUR;
            w_dp  = (r_state == ST_RUN) ? r_sec[0] : 1'b1;
        end else if (r_sel == SEL_W'(OFS + 3)) begin
            w_val   = w_dh2;
            w_fld   = ST_SET_HOUR;
            w_blank = h12 && (w_hour12 < 5'd10);
        end else if (r_sel == '0) begin
            w_val = 4'(r_sec % 6'd10);
            w_fld = ST_SET_SEC;
        end else begin
            w_val = 4'(r_sec / 6'd10);
            w_fld = ST_SET_SEC;
        end
        if (r_sel == '0) w_dp = h12 && (w_hour_bin >= 5'd12);
        // Field being edited flashes off during the second half of each second
        if (r_state != ST_RUN && w_fld == r_state && r_div >= DIV_W'(CLK_HZ / 2))
            w_blank = 1'b1;
    end

    function automatic logic [6:0] f_seg7(input logic [3:0] i_v);
        case (i_v)
            4'd0:    f_seg7 = 7'h3F;
            4'd1:    f_seg7 = 7'h06;
            4'd2:    f_seg7 = 7'h5B;
            4'd3:    f_seg7 = 7'h4F;
            4'd4:    f_seg7 = 7'h66;
            4'd5:    f_seg7 = 7'h6D;
            4'd6:    f_seg7 = 7'h7D;
            4'd7:    f_seg7 = 7'h07;
            4'd8:    f_seg7 = 7'h7F;
            4'd9:    f_seg7 = 7'h6F;
            default: f_seg7 = 7'h79;
        endcase
    endfunction

    assign seg = {w_dp, w_blank ? 7'd0 : f_seg7(w_val)};
    assign d   = r_d;

endmodule

// File: tb/tb_param_clock.sv
`timescale 1ns/1ps
// tb_param_clock: random and directed stimulus for param_clock, compared every
// cycle against a seconds-of-day reference model of the clock and its display.
module tb_param_clock;

    localparam int CLK_HZ = 8;
    localparam int ND     = 6;
    localparam int SB     = 2;
    localparam int BB     = 2;
    localparam int RD     = 16;
    localparam int RR     = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_set;
    logic          btn_inc;
    logic          h12;
    logic [7:0]    seg;
    logic [ND-1:0] d;

    param_clock #(
        .CLK_HZ(CLK_HZ), .NUM_DIGITS(ND), .SCAN_BITS(SB),
        .BTN_BITS(BB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst), .btn_set(btn_set), .btn_inc(btn_inc),
        .h12(h12), .seg(seg), .d(d)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int stride   = 1;
    int cyc_n    = 0;

    // Reference model: time as seconds of day, mode 0=RUN 1=HOUR 2=MIN 3=SEC
    int m_tod, m_div, m_cnt, m_mode, m_hold;
    bit m_set_q, m_inc_q;

    logic [7:0] codes [0:9];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tod = 0; m_div = 0; m_cnt = 0; m_mode = 0; m_hold = 0;
        m_set_q = 0; m_inc_q = 0;
    endtask

    task automatic model_edge();
        bit smp, set_ev, inc_ev;
        int hh, mm;
        if (rst) begin
            model_reset();
            return;
        end
        smp    = (m_cnt % (1 << BB)) == 0;
        set_ev = smp && btn_set && !m_set_q;
        inc_ev = 0;
        if (smp) begin
            if (btn_inc && !m_inc_q) begin
                inc_ev = 1; m_hold = 0;
            end else if (btn_inc) begin
                m_hold++;
                if (m_hold == RD || (m_hold > RD && (m_hold - RD) % RR == 0)) inc_ev = 1;
            end else begin
                m_hold = 0;
            end
            m_set_q = btn_set;
            m_inc_q = btn_inc;
        end
        hh = m_tod / 3600;
        mm = (m_tod / 60) % 60;
        if (inc_ev && m_mode != 0) begin
            if (m_mode == 1)      m_tod = ((hh + 1) % 24) * 3600 + mm * 60;
            else if (m_mode == 2) m_tod = hh * 3600 + ((mm + 1) % 60) * 60;
            else                  m_tod = hh * 3600 + mm * 60;
            m_div = 0;
        end else if (m_div == CLK_HZ - 1) begin
            m_div = 0;
            m_tod = (m_tod + 1) % 86400;
        end else begin
            m_div++;
        end
        if (set_ev) m_mode = (m_mode == 3 || (m_mode == 2 && ND == 4)) ? 0 : m_mode + 1;
        m_cnt++;
    endtask

    function automatic logic [7:0] exp_seg(input int idx);
        int hh, mm, ss, dh, pos, val, fld;
        bit blank, dp;
        hh = m_tod / 3600; mm = (m_tod / 60) % 60; ss = m_tod % 60;
        dh = hh;
        if (h12) begin
            if (hh == 0)     dh = 12;
            else if (hh > 12) dh = hh - 12;
        end
        pos = idx - (ND - 4);
        blank = 0; dp = 0; val = 0; fld = 0;
        case (pos)
            -2: begin val = ss % 10; fld = 3; end
            -1: begin val = ss / 10; fld = 3; end
            0:  begin val = mm % 10; fld = 2; end
            1:  begin val = mm / 10; fld = 2; end
            2:  begin val = dh % 10; fld = 1; dp = (m_mode == 0) ? (ss % 2 == 1) : 1'b1; end
            3:  begin val = dh / 10; fld = 1; blank = h12 && dh < 10; end
            default: ;
        endcase
        if (idx == 0) dp = h12 && hh >= 12;
        if (m_mode != 0 && m_mode == fld && m_div >= CLK_HZ / 2) blank = 1;
        return {dp, blank ? 7'd0 : codes[val][6:0]};
    endfunction

    task automatic check_display();
        int idx;
        logic [ND-1:0] ed;
        idx = (m_cnt >> SB) % ND;
        ed = '1;
        ed[idx] = 1'b0;
        chk("d", 32'(d), 32'(ed));
        chk("seg", 32'(seg), 32'(exp_seg(idx)));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc_n++;
        if (cyc_n % stride == 0) check_display();
    endtask

    task automatic press(input bit is_set);
        int hi, lo;
        hi = $urandom_range(5, 12);
        lo = $urandom_range(5, 12);
        if (is_set) btn_set = 1'b1; else btn_inc = 1'b1;
        repeat (hi) cycle();
        btn_set = 1'b0;
        btn_inc = 1'b0;
        repeat (lo) cycle();
    endtask

    // From RUN: walk the set sequence to reach hh:mm with seconds zeroed
    task automatic set_time(input int h, input int m);
        int guard;
        press(1'b1);
        guard = 0;
        while (m_tod / 3600 != h && guard < 30) begin press(1'b0); guard++; end
        press(1'b1);
        guard = 0;
        while ((m_tod / 60) % 60 != m && guard < 70) begin press(1'b0); guard++; end
        press(1'b1);
        if (ND == 6) begin press(1'b0); press(1'b1); end
    endtask

    // Scan all digit positions once and compare hour/minute digits with constants
    task automatic check_hm(input int hd, input int mm, input bit blank_h2, input bit pm);
        bit done [ND];
        int idx, pos;
        for (int i = 0; i < ND; i++) done[i] = 0;
        for (int k = 0; k < ND * (1 << SB) + 2; k++) begin
            cycle();
            idx = (m_cnt >> SB) % ND;
            pos = idx - (ND - 4);
            if (!done[idx]) begin
                done[idx] = 1;
                if (idx == 0) chk("hm_pm", 32'(seg[7]), 32'(pm));
                case (pos)
                    0: chk("hm_min1",  32'(seg[6:0]), 32'(codes[mm % 10][6:0]));
                    1: chk("hm_min2",  32'(seg[6:0]), 32'(codes[mm / 10][6:0]));
                    2: chk("hm_hour1", 32'(seg[6:0]), 32'(codes[hd % 10][6:0]));
                    3: chk("hm_hour2", 32'(seg[6:0]), blank_h2 ? 32'd0 : 32'(codes[hd / 10][6:0]));
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        int guard;
        codes[0] = 8'h3F; codes[1] = 8'h06; codes[2] = 8'h5B; codes[3] = 8'h4F;
        codes[4] = 8'h66; codes[5] = 8'h6D; codes[6] = 8'h7D; codes[7] = 8'h07;
        codes[8] = 8'h7F; codes[9] = 8'h6F;

        rst = 1'b1; btn_set = 1'b0; btn_inc = 1'b0; h12 = 1'b0;
        model_reset();
        #3;
        chk("rst_d",   32'(d),   32'h3E);
        chk("rst_seg", 32'(seg), 32'h3F);
        repeat (2) cycle();
        rst = 1'b0;

        // One hour of ticks from reset
        stride = 7;
        repeat (CLK_HZ * 3600) cycle();
        stride = 1;
        check_hm(1, 0, 1'b0, 1'b0);

        // 22:30, then three hour increments wrap to 01:30
        set_time(22, 30);
        check_hm(22, 30, 1'b0, 1'b0);
        press(1'b1);
        repeat (3) press(1'b0);
        repeat (3) press(1'b1);
        check_hm(1, 30, 1'b0, 1'b0);

        // Minute wrap in SET_MIN does not carry into hour
        set_time(5, 59);
        press(1'b1); press(1'b1); press(1'b0); press(1'b1); press(1'b1);
        check_hm(5, 0, 1'b0, 1'b0);

        // Held increment: press sample plus 28 held samples -> five events
        set_time(7, 0);
        press(1'b1); press(1'b1);
        guard = 0;
        while (m_cnt % (1 << BB) != 1 && guard < 8) begin cycle(); guard++; end
        btn_inc = 1'b1;
        repeat (29 * (1 << BB)) cycle();
        btn_inc = 1'b0;
        repeat (8) cycle();
        press(1'b1); press(1'b1);
        check_hm(7, 5, 1'b0, 1'b0);

        // 12-hour display
        set_time(0, 15);
        h12 = 1'b1;
        check_hm(12, 15, 1'b0, 1'b0);
        set_time(13, 5);
        check_hm(1, 5, 1'b1, 1'b1);
        h12 = 1'b0;
        check_hm(13, 5, 1'b0, 1'b0);

        // Day rollover through 23:59:59
        set_time(23, 59);
        repeat (CLK_HZ * 60) cycle();
        check_hm(0, 0, 1'b0, 1'b0);

        // Random buttons and display mode
        while (cyc_n < CLK_HZ * 3600 + 12000) begin
            btn_set = ($urandom_range(0, 5) == 0);
            btn_inc = ($urandom_range(0, 2) == 0);
            h12     = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, btn_inc ? 120 : 40)) cycle();
        end
        btn_set = 1'b0; btn_inc = 1'b0; h12 = 1'b0;
        repeat (8) cycle();
        guard = 0;
        while (m_mode != 0 && guard < 4) begin press(1'b1); guard++; end

        // Asynchronous reset in SET_HOUR at 14:22:37
        set_time(14, 22);
        press(1'b1);
        guard = 0;
        while (!(m_tod % 60 == 37 && ((m_cnt >> SB) % ND) != 0) && guard < 2000) begin
            cycle(); guard++;
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_d",   32'(d),   32'h3E);
        chk("arst_seg", 32'(seg), 32'h3F);
        repeat (2) cycle();
        rst = 1'b0;
        press(1'b0);
        check_hm(0, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
